// File: rtl/io_port_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// io_port_ctrl_pkg
// Shared definitions for the keypad/display port controller:
//   - default widths of the input (keypad) and output (display) interfaces
//   - output command encodings carried in every display queue entry
// -----------------------------------------------------------------------------
package io_port_ctrl_pkg;

   // Output-interface defaults
   localparam int OD_N_DEF  = 32;  // display payload width
   localparam int OC_N_DEF  = 2;   // display command width
   localparam int DEPTH_DEF = 4;   // display queue depth

   // Input-interface defaults
   localparam int IC_N_DEF  = 5;   // keypad command width

   // Display command encodings; OC_NON is all-zero so an empty head reads as idle
   typedef enum logic [1:0] {
      OC_NON = 2'd0,
      OC_ACK = 2'd1,
      OC_NUM = 2'd2
   } out_cmd_e;

endpackage

// File: rtl/io_port_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Synchronous FIFO with a zero-latency head: the oldest entry is read straight
// out of storage, so it is visible the cycle after it is written.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   push, wdata  : write request and data (dropped when full unless popping)
//   pop          : remove head entry (ignored when empty)
//   head         : oldest entry, zero when empty
//   empty, full  : occupancy status
// -----------------------------------------------------------------------------
module io_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [PW-1:0] PTR_ZERO = PW'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             empty_s;
   logic             full_s;
   logic             pop_ok_s;
   logic             push_ok_s;

   assign empty_s   = (count_r == CNT_ZERO);
   assign full_s    = (count_r == CNT_FULL);
   assign pop_ok_s  = pop & ~empty_s;
   // A pop in the same cycle frees a slot, so a push into a full queue still lands
   assign push_ok_s = push & (~full_s | pop_ok_s);

   assign empty = empty_s;
   assign full  = full_s;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents need no reset because the head is masked while empty
   always_ff @(posedge Clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Head presentation straight from storage
   always_comb begin
      if (empty_s) begin
         head = WIDTH'(0);
      end else begin
         head = mem_r[rd_ptr_r];
      end
   end

endmodule

// File: rtl/io_port_ctrl.sv
// -----------------------------------------------------------------------------
// io_port_ctrl
// Keypad-to-controller command capture plus a controller-to-display output queue.
// Ports:
//   Clock, Reset          : clock and synchronous active-high reset
//   in_valid, in_cmd      : keypad offers a command
//   in_ack                : one-cycle acknowledge, the cycle after a capture
//   cmd_valid, cmd_data   : captured command held for the controller
//   cmd_take              : controller consumes the held command
//   req_ack               : enqueue {OC_ACK, 0} (wins over req_num)
//   req_num, req_data     : enqueue {OC_NUM, req_data}
//   out_valid/cmd/data    : display queue head (OC_NON / 0 when empty)
//   out_ready             : display accepts the head
//   q_full                : display queue full
//   overflow              : sticky, some request was dropped
// -----------------------------------------------------------------------------
module io_port_ctrl
   import io_port_ctrl_pkg::*;
#(
   parameter int OD_N  = OD_N_DEF,
   parameter int OC_N  = OC_N_DEF,
   parameter int IC_N  = IC_N_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            in_valid,
   input  logic [IC_N-1:0] in_cmd,
   output logic            in_ack,
   output logic            cmd_valid,
   output logic [IC_N-1:0] cmd_data,
   input  logic            cmd_take,
   input  logic            req_ack,
   input  logic            req_num,
   input  logic [OD_N-1:0] req_data,
   output logic            out_valid,
   output logic [OC_N-1:0] out_cmd,
   output logic [OD_N-1:0] out_data,
   input  logic            out_ready,
   output logic            q_full,
   output logic            overflow
);

   localparam int EW = OC_N + OD_N;

   logic            in_ack_r;
   logic            cmd_valid_r;
   logic [IC_N-1:0] cmd_data_r;
   logic            overflow_r;

   logic            capture_s;
   logic            push_req_s;
   logic            pop_s;
   logic            drop_s;
   logic [EW-1:0]   wdata_s;
   logic [EW-1:0]   head_s;
   logic            fifo_empty_s;
   logic            fifo_full_s;

   // A new command is taken when the holding slot is free or being vacated now
   assign capture_s  = in_valid & (~cmd_valid_r | cmd_take);
   assign push_req_s = req_ack | req_num;
   assign pop_s      = ~fifo_empty_s & out_ready;
   // Lost requests: req_num shadowed by req_ack, or any push into a full queue with no pop
   assign drop_s     = (req_ack & req_num) | (push_req_s & fifo_full_s & ~pop_s);

   // Entry selection; req_ack has priority over req_num
   always_comb begin
      if (req_ack) begin
         wdata_s = {OC_N'(OC_ACK), OD_N'(0)};
      end else begin
         wdata_s = {OC_N'(OC_NUM), req_data};
      end
   end

   // Keypad capture, acknowledge pulse and sticky overflow
   always_ff @(posedge Clock) begin
      if (Reset) begin
         in_ack_r    <= 1'b0;
         cmd_valid_r <= 1'b0;
         cmd_data_r  <= IC_N'(0);
         overflow_r  <= 1'b0;
      end else begin
         in_ack_r <= capture_s;
         if (capture_s) begin
            cmd_valid_r <= 1'b1;
            cmd_data_r  <= in_cmd;
         end else if (cmd_take) begin
            cmd_valid_r <= 1'b0;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   io_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (push_req_s),
      .wdata (wdata_s),
      .pop   (pop_s),
      .head  (head_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   // Head split into command/data; an empty queue shows OC_NON
   always_comb begin
      if (fifo_empty_s) begin
         out_cmd  = OC_N'(OC_NON);
         out_data = OD_N'(0);
      end else begin
         out_cmd  = head_s[OD_N +: OC_N];
         out_data = head_s[OD_N-1:0];
      end
   end

   assign out_valid = ~fifo_empty_s;
   assign q_full    = fifo_full_s;
   assign in_ack    = in_ack_r;
   assign cmd_valid = cmd_valid_r;
   assign cmd_data  = cmd_data_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_io_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_port_ctrl
// Directed scenarios followed by random traffic, every cycle compared against a
// queue-based reference model of the port controller.
// -----------------------------------------------------------------------------
module tb_io_port_ctrl;

   localparam int OD_N  = 32;
   localparam int OC_N  = 2;
   localparam int IC_N  = 5;
   localparam int DEPTH = 4;

   localparam logic [1:0] C_NON = 2'd0;
   localparam logic [1:0] C_ACK = 2'd1;
   localparam logic [1:0] C_NUM = 2'd2;

   logic            Clock = 1'b0;
   logic            Reset;
   logic            in_valid;
   logic [IC_N-1:0] in_cmd;
   logic            in_ack;
   logic            cmd_valid;
   logic [IC_N-1:0] cmd_data;
   logic            cmd_take;
   logic            req_ack;
   logic            req_num;
   logic [OD_N-1:0] req_data;
   logic            out_valid;
   logic [OC_N-1:0] out_cmd;
   logic [OD_N-1:0] out_data;
   logic            out_ready;
   logic            q_full;
   logic            overflow;

   always #5 Clock = ~Clock;

   io_port_ctrl #(.OD_N(OD_N), .OC_N(OC_N), .IC_N(IC_N), .DEPTH(DEPTH)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_cmd    (in_cmd),
      .in_ack    (in_ack),
      .cmd_valid (cmd_valid),
      .cmd_data  (cmd_data),
      .cmd_take  (cmd_take),
      .req_ack   (req_ack),
      .req_num   (req_num),
      .req_data  (req_data),
      .out_valid (out_valid),
      .out_cmd   (out_cmd),
      .out_data  (out_data),
      .out_ready (out_ready),
      .q_full    (q_full),
      .overflow  (overflow)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [OC_N+OD_N-1:0] m_q [$];
   logic                 m_cmd_valid = 1'b0;
   logic [IC_N-1:0]      m_cmd_data  = '0;
   logic                 m_ack       = 1'b0;
   logic                 m_ovf       = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [OC_N+OD_N-1:0] h;
      h = (m_q.size() != 0) ? m_q[0] : '0;
      check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      check("out_cmd",   64'(out_cmd),   64'(h[OD_N +: OC_N]));
      check("out_data",  64'(out_data),  64'(h[OD_N-1:0]));
      check("q_full",    64'(q_full),    64'(m_q.size() == DEPTH));
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("in_ack",    64'(in_ack),    64'(m_ack));
      check("cmd_valid", 64'(cmd_valid), 64'(m_cmd_valid));
      check("cmd_data",  64'(cmd_data),  64'(m_cmd_data));
   endtask

   // One clock of the behavioural model using the currently driven inputs
   task automatic model_step();
      int  sz;
      bit  pop;
      bit  cap;
      logic [OC_N+OD_N-1:0] e;
      if (Reset) begin
         m_q.delete();
         m_cmd_valid = 1'b0;
         m_cmd_data  = '0;
         m_ack       = 1'b0;
         m_ovf       = 1'b0;
      end else begin
         cap   = in_valid && (!m_cmd_valid || cmd_take);
         m_ack = cap;
         if (cap) begin
            m_cmd_valid = 1'b1;
            m_cmd_data  = in_cmd;
         end else if (cmd_take) begin
            m_cmd_valid = 1'b0;
         end
         sz  = m_q.size();
         pop = (sz > 0) && out_ready;
         if (req_ack && req_num) m_ovf = 1'b1;
         if (pop) void'(m_q.pop_front());
         if (req_ack || req_num) begin
            e = req_ack ? {C_ACK, 32'h0} : {C_NUM, req_data};
            if (sz < DEPTH || pop) m_q.push_back(e);
            else m_ovf = 1'b1;
         end
      end
   endtask

   // Check state at the falling edge, advance the model, then pass the rising edge
   task automatic tick(input bit chk);
      @(negedge Clock);
      if (chk) check_all();
      model_step();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_cmd = '0; cmd_take = 1'b0;
      req_ack = 1'b0; req_num = 1'b0; req_data = '0; out_ready = 1'b0;
   endtask

   initial begin
      int acks;
      idle_inputs();
      Reset = 1'b1;
      tick(1'b0);
      tick(1'b0);
      Reset = 1'b0;
      tick(1'b1);

      // Held keypad command: one ack only, command stays valid
      in_valid = 1'b1; in_cmd = 5'h0A; acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         acks += int'(in_ack);
      end
      in_valid = 1'b0;
      check("r035_acks",  64'(acks),      64'd1);
      check("r035_data",  64'(cmd_data),  64'h0A);
      check("r035_valid", 64'(cmd_valid), 64'd1);
      cmd_take = 1'b1; tick(1'b1); cmd_take = 1'b0;

      // Single number entry held until the display accepts
      req_num = 1'b1; req_data = 32'h0000_1234; tick(1'b1); req_num = 1'b0;
      check("r036_valid", 64'(out_valid), 64'd1);
      check("r036_cmd",   64'(out_cmd),   64'(C_NUM));
      check("r036_data",  64'(out_data),  64'h1234);
      tick(1'b1); tick(1'b1);
      check("r036_hold",  64'(out_data),  64'h1234);
      out_ready = 1'b1; tick(1'b1); out_ready = 1'b0;
      check("r036_drain", 64'(out_valid), 64'd0);

      // Full queue with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         req_num = 1'b1; req_data = 32'hA0 + 32'(i); tick(1'b1);
      end
      check("r038_full_before", 64'(q_full), 64'd1);
      req_data = 32'hB0; out_ready = 1'b1; tick(1'b1);
      req_num = 1'b0; out_ready = 1'b0;
      check("r038_full_after", 64'(q_full),   64'd1);
      check("r038_overflow",   64'(overflow), 64'd0);
      check("r038_head",       64'(out_data), 64'hA1);
      Reset = 1'b1; tick(1'b1); Reset = 1'b0;

      // Five pushes into a depth-4 queue, then drain in order
      for (int i = 0; i < 5; i++) begin
         req_num = 1'b1; req_data = 32'h100 + 32'(i); tick(1'b1);
         if (i == 3) begin
            check("r037_full4", 64'(q_full),   64'd1);
            check("r037_ovf4",  64'(overflow), 64'd0);
         end
      end
      req_num = 1'b0;
      check("r037_ovf5", 64'(overflow), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("r037_order", 64'(out_data), 64'h100 + 64'(i));
         tick(1'b1);
      end
      out_ready = 1'b0;
      check("r037_empty", 64'(out_valid), 64'd0);
      Reset = 1'b1; tick(1'b1); Reset = 1'b0;

      // ACK and NUM together: one ACK entry, overflow set
      req_ack = 1'b1; req_num = 1'b1; req_data = 32'hDEAD; tick(1'b1);
      req_ack = 1'b0; req_num = 1'b0;
      check("r039_cmd",  64'(out_cmd),  64'(C_ACK));
      check("r039_data", 64'(out_data), 64'd0);
      check("r039_ovf",  64'(overflow), 64'd1);
      out_ready = 1'b1; tick(1'b1); out_ready = 1'b0;
      check("r039_single", 64'(out_valid), 64'd0);
      Reset = 1'b1; tick(1'b1); Reset = 1'b0;

      // Reset in the middle of traffic
      in_valid = 1'b1; in_cmd = 5'h07;
      for (int i = 0; i < 3; i++) begin
         req_num = 1'b1; req_data = 32'h300 + 32'(i); tick(1'b1);
      end
      req_num = 1'b0;
      Reset = 1'b1; tick(1'b1); Reset = 1'b0;
      check("r040_valid", 64'(out_valid), 64'd0);
      check("r040_cmd",   64'(out_cmd),   64'(C_NON));
      check("r040_full",  64'(q_full),    64'd0);
      check("r040_ack",   64'(in_ack),    64'd0);
      check("r040_cv",    64'(cmd_valid), 64'd0);
      check("r040_cd",    64'(cmd_data),  64'd0);
      in_valid = 1'b0;
      req_num = 1'b1; req_data = 32'h55; tick(1'b1); req_num = 1'b0;
      check("r040_after", 64'(out_data), 64'h55);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         Reset     = ($urandom_range(0, 79) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         in_cmd    = IC_N'($urandom);
         cmd_take  = $urandom_range(0, 2) == 0;
         req_ack   = $urandom_range(0, 5) == 0;
         req_num   = $urandom_range(0, 2) == 0;
         req_data  = $urandom;
         out_ready = $urandom_range(0, 2) == 0;
         tick(1'b1);
      end
      Reset = 1'b0;
      idle_inputs();
      tick(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter OD_N, default 32: output data width in bits.
REQ-002 Parameter OC_N, default 2: output command width in bits.
REQ-003 Parameter IC_N, default 5: input command width in bits.
REQ-004 Parameter DEPTH, default 4: output queue depth; power of two, at least 2.
REQ-005 Port Clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: keypad offers in_cmd.
REQ-008 Port in_cmd, input, IC_N bits: keypad command.
REQ-009 Port in_ack, output, 1 bit: registered acknowledge to keypad.
REQ-010 Port cmd_valid, output, 1 bit: captured command available to controller.
REQ-011 Port cmd_data, output, IC_N bits: captured command.
REQ-012 Port cmd_take, input, 1 bit: controller consumes cmd_data.
REQ-013 Port req_ack, input, 1 bit: controller requests an OC_ACK output entry.
REQ-014 Port req_num, input, 1 bit: controller requests an OC_NUM output entry.
REQ-015 Port req_data, input, OD_N bits: payload for req_num.
REQ-016 Port out_valid, output, 1 bit: head queue entry valid.
REQ-017 Port out_cmd, output, OC_N bits: head command, OC_NON when empty.
REQ-018 Port out_data, output, OD_N bits: head data, zero when empty.
REQ-019 Port out_ready, input, 1 bit: display accepts head entry.
REQ-020 Port q_full, output, 1 bit: output queue full.
REQ-021 Port overflow, output, 1 bit: sticky flag, request dropped.

Function
REQ-022 Input capture: the block SHALL latch in_cmd when in_valid=1 and cmd_valid=0 (or cmd_take=1 in the same cycle) and SHALL set cmd_valid the next cycle.
REQ-023 in_ack SHALL be 1 for exactly one cycle, in the cycle after each capture; in_valid held high without a new capture SHALL NOT produce further acks.
REQ-024 cmd_take with cmd_valid=0 SHALL be ignored; cmd_take together with in_valid SHALL replace the held command with zero bubble.
REQ-025 Output enqueue: req_num SHALL push {OC_NUM, req_data}; req_ack SHALL push {OC_ACK, 0}; if both are 1, req_ack SHALL take priority and req_num SHALL be dropped, setting overflow.
REQ-026 Dequeue SHALL occur when out_valid=1 and out_ready=1; the head SHALL be presented directly from queue storage (zero-latency head, no bubble).
REQ-027 An enqueue into an empty queue SHALL make out_valid=1 in the following cycle.
REQ-028 Full: a push while full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-029 Simultaneous push and pop on a non-empty queue SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH; occupancy counter width SHALL be clog2(DEPTH)+1.
REQ-030 overflow SHALL remain 1 until Reset.

Reset
REQ-031 While Reset=1 at a clock edge: queue emptied, cmd_valid=0, cmd_data=0, in_ack=0, overflow=0, out_valid=0, out_cmd=OC_NON, out_data=0, q_full=0.
REQ-032 Reset asserted mid-operation SHALL discard queued entries and any held command, with no ack issued for the reset cycle.

Structure
REQ-033 OC_NON/OC_ACK/OC_NUM encodings and the default widths SHALL live in the shared output-interface include; IC_N defaults SHALL come from the input-interface include.
REQ-034 The queue SHALL be one sub-module, io_fifo (parameters WIDTH, DEPTH), instantiated with WIDTH=OC_N+OD_N.

Verification
REQ-035 in_valid=1, in_cmd=5'h0A for 3 cycles, no take -> one in_ack pulse, cmd_data=0x0A, cmd_valid stays 1.
REQ-036 req_num with 0x0000_1234, out_ready=0 -> next cycle out_valid=1, out_cmd=OC_NUM, out_data=0x1234; hold until out_ready.
REQ-037 DEPTH=4, five req_num pushes with out_ready=0 -> q_full=1 after the 4th; 5th dropped; overflow=1; four entries drain in order.
REQ-038 Full queue, push and pop in the same cycle -> push accepted, q_full stays 1, overflow stays 0.
REQ-039 req_ack and req_num in the same cycle -> single OC_ACK entry with data 0, overflow=1.
REQ-040 Reset pulse with 3 entries queued and cmd_valid=1 -> next cycle all outputs at reset values; later traffic unaffected.
